mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-port SRAM between the instruction-fetch requester (I, read-only) and the data-memory requester (D, read/write). This lets the pipeline run on a unified instruction/data memory.
- Multi-cycle FSM with a fixed memory read latency. D has priority; a starvation counter guarantees forward progress for fetch.
- Sits between the fetch/MEM pipeline stages and the memory macro; its grant/valid signals drive the hazard unit's stalls.

Parameters:
- ADDR_W, 16, address width to memory.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from address presented to mem_rdata valid; legal range 1..8.
- STARVE_LIMIT, 4, consecutive D grants while I waits before I is forced; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- i_req  in  1  fetch request
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch data valid (1-cycle pulse)
- i_rdata  out  DATA_W  fetch data
- d_req  in  1  data request
- d_addr  in  ADDR_W  data address
- d_wen  in  4  byte write enables; 0 = read
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted
- d_rvalid  out  1  load data valid / store ack (1-cycle pulse)
- d_rdata  out  DATA_W  load data
- mem_addr  out  ADDR_W  memory address
- mem_wen  out  4  memory byte write enables
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, async) sets:
  - state=IDLE; owner=I; lat_cnt=0; starve_cnt=0.
  - All outputs 0, including mem_wen, rdata registers, gnt and rvalid.
- Reset mid-operation aborts the transaction: no rvalid is issued, and a write already presented is not undone.
- States: IDLE, WRITE, READ, RESP.
- IDLE:
  - Combinational arbitration; winner's x_gnt=1 in the same cycle.
  - Winner is D if d_req, unless i_req && starve_cnt==STARVE_LIMIT, in which case I wins. Otherwise I wins if i_req.
  - At the clock edge, addr/wen/wdata and owner are latched into the mem_* registers.
  - Next state: D with d_wen!=0 -> WRITE. Any read -> READ with lat_cnt=MEM_LAT. No request -> stay in IDLE, mem_wen=0.
- WRITE: mem_wen=latched d_wen for exactly 1 cycle; d_rvalid=1 (ack), d_rdata unchanged -> IDLE.
- READ:
  - mem_wen=0; mem_addr held; lat_cnt decrements each cycle.
  - On the cycle lat_cnt==1, mem_rdata is captured into the owner's rdata register -> RESP.
- RESP: owner's rvalid=1 for 1 cycle -> IDLE. rdata holds its value until the next response to that owner.
- Read latency: gnt in cycle 0, rvalid in cycle MEM_LAT+1. Read occupancy is MEM_LAT+2 cycles; write occupancy is 2 cycles.
- Starvation counter:
  - At each D grant, starve_cnt increments (saturating at STARVE_LIMIT) if i_req=1, else clears to 0.
  - An I grant clears it to 0.
- Request hold rules:
  - Requesters hold req/addr/wen/wdata stable until gnt.
  - Requests arriving outside IDLE receive gnt=0 and are not lost if held.
  - req may remain high after gnt to issue a new request.
- i_gnt and d_gnt are never high in the same cycle. i_rvalid and d_rvalid are never high in the same cycle.
- Addresses are passed through unmodified (no alignment check); the filter/alignment logic lives elsewhere.

Optional Feature:
- Macro MEM_ARB_PERF_CNT_EN.
- Defined:
  - Adds output conflict_cnt (32 bits), reset 0.
  - Increments on every IDLE cycle with i_req && d_req; wraps modulo 2^32.
  - Adds output starve_hits (16 bits), which increments whenever I wins because of the starvation rule; saturates at 0xFFFF.
- Undefined: both ports and all associated logic are absent. All other behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, WRITE, READ, RESP).
  - owner encoding (OWN_I=0, OWN_D=1).
  - LAT_W=4 and STARVE_W=4 constants.
- One sub-module, mem_arb_prio: combinational winner select plus the starve_cnt register. The top module holds the FSM, latency counter and data registers.

Test Plan:
- Reset: hold rst=0 with i_req=d_req=1. Expected: all outputs 0, no gnt. Release rst; next cycle d_gnt=1.
- Single fetch read (MEM_LAT=1): i_req=1, i_addr=0x0010, memory word 0x00A00093. Expected: i_gnt in cycle 0, i_rvalid=1 with i_rdata=0x00A00093 in cycle 2, busy=1 in cycles 1-2.
- Store: d_req=1, d_addr=0x0100, d_wen=4'b0011, d_wdata=0xDEADBEEF. Expected: mem_wen=4'b0011 for exactly 1 cycle, d_rvalid ack in the same cycle, back in IDLE next cycle.
- Starvation (STARVE_LIMIT=4): i_req and d_req held high continuously. Expected grant order D,D,D,D,I,D..., with i_gnt on the 5th grant.
- Latency sweep, MEM_LAT=3, D load: expected d_rvalid exactly 4 cycles after d_gnt. Separately, a request raised in READ receives no gnt until IDLE.
- Mid-read reset: assert rst in the READ state. Expected: no rvalid; state IDLE; starve_cnt=0. With MEM_ARB_PERF_CNT_EN, conflict_cnt=0 after reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified I/D memory arbiter.
//   state_e : arbiter FSM states
//   owner_e : which requester owns the transaction in flight
//   LAT_W   : width of the read-latency down-counter (MEM_LAT up to 8)
//   STARVE_W: width of the fetch starvation counter (STARVE_LIMIT up to 15)
package mem_arb_pkg;
  localparam int LAT_W    = 4;
  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_e;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/response bundle between the fetch (I) and data (D)
// requesters, the arbiter, and the single-port SRAM macro.
//   slave  : arbiter view (takes requests and mem_rdata, drives grants/responses/mem_*)
//   master : environment view (requesters + memory macro)
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [3:0]        d_wen;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wen, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wen, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_wen, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wen, mem_wdata
  );
endinterface

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: winner select between fetch (I) and data (D) plus the
// starvation counter that forces an I grant after STARVE_LIMIT consecutive
// D grants taken while I was waiting.
//   clk, rst       : clock, async active-low reset
//   i_en           : arbitration window (FSM idle and out of reset)
//   i_ireq, i_dreq : raw requests
//   o_iwin, o_dwin : one-hot (or none) winner, combinational
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_ireq,
  input  logic i_dreq,
  output logic o_iwin,
  output logic o_dwin
);
  logic [STARVE_W-1:0] r_starve_cnt;
  logic                w_forced;

  assign w_forced = i_ireq && (r_starve_cnt == STARVE_W'(STARVE_LIMIT));
  assign o_dwin   = i_en && i_dreq && !w_forced;
  assign o_iwin   = i_en && i_ireq && !o_dwin;

  // Counts D grants taken over a waiting fetch; any grant with I idle resets it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (o_dwin) begin
      if (!i_ireq)
        r_starve_cnt <= '0;
      else if (r_starve_cnt != STARVE_W'(STARVE_LIMIT))
        r_starve_cnt <= r_starve_cnt + 1'b1;
    end else if (o_iwin) begin
      r_starve_cnt <= '0;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port SRAM between instruction fetch (I,
// read-only) and data memory (D, read/write). D has priority; a starvation
// counter guarantees fetch progress. Reads take MEM_LAT+2 cycles of
// occupancy (grant, MEM_LAT in READ, RESP), writes take 2 (grant, WRITE).
//   clk, rst : clock, asynchronous active-low reset
//   bus      : mem_arbiter_if.slave (requests, grants, responses, mem_*)
//   busy     : high whenever the FSM is not in IDLE
// Optional build macro MEM_ARB_PERF_CNT_EN adds:
//   conflict_cnt : IDLE cycles with both requests pending (wraps)
//   starve_hits  : I grants forced by the starvation rule (saturates)
// ADDR_W/DATA_W must match the parameters of the connected interface.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_arbiter_if.slave       bus,
  output logic               busy
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]        conflict_cnt,
  output logic [15:0]        starve_hits
`endif
);
  state_e            r_state, w_next;
  owner_e            r_owner;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [3:0]        r_mem_wen;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_i_rdata, r_d_rdata;
  logic              w_idle, w_iwin, w_dwin;

  // Gate arbitration with rst so no grant escapes while reset is held.
  assign w_idle = (r_state == IDLE) && rst;

  mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_idle),
    .i_ireq (bus.i_req),
    .i_dreq (bus.d_req),
    .o_iwin (w_iwin),
    .o_dwin (w_dwin)
  );

  assign bus.i_gnt     = w_iwin;
  assign bus.d_gnt     = w_dwin;
  assign bus.i_rvalid  = (r_state == RESP) && (r_owner == OWN_I);
  assign bus.d_rvalid  = ((r_state == RESP) && (r_owner == OWN_D)) || (r_state == WRITE);
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wen   = r_mem_wen;
  assign bus.mem_wdata = r_mem_wdata;
  assign busy          = (r_state != IDLE);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_dwin && |bus.d_wen) w_next = WRITE;
               else if (w_dwin || w_iwin) w_next = READ;
      WRITE:   w_next = IDLE;
      READ:    if (r_lat_cnt == LAT_W'(1)) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_owner     <= OWN_I;
      r_lat_cnt   <= '0;
      r_mem_addr  <= '0;
      r_mem_wen   <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_state   <= w_next;
      // Byte enables live for exactly the WRITE cycle; cleared everywhere else.
      r_mem_wen <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_dwin) begin
            r_owner     <= OWN_D;
            r_mem_addr  <= bus.d_addr;
            r_mem_wen   <= bus.d_wen;
            r_mem_wdata <= bus.d_wdata;
            r_lat_cnt   <= LAT_W'(MEM_LAT);
          end else if (w_iwin) begin
            r_owner     <= OWN_I;
            r_mem_addr  <= bus.i_addr;
            r_lat_cnt   <= LAT_W'(MEM_LAT);
          end
        end
        READ: begin
          r_lat_cnt <= r_lat_cnt - 1'b1;
          if (r_lat_cnt == LAT_W'(1)) begin
            if (r_owner == OWN_D) r_d_rdata <= bus.mem_rdata;
            else                  r_i_rdata <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] r_conflict_cnt;
  logic [15:0] r_starve_hits;

  assign conflict_cnt = r_conflict_cnt;
  assign starve_hits  = r_starve_hits;

  // An I win while D is also requesting can only come from the starvation rule.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_conflict_cnt <= '0;
      r_starve_hits  <= '0;
    end else begin
      if (w_idle && bus.i_req && bus.d_req)
        r_conflict_cnt <= r_conflict_cnt + 1'b1;
      if (w_iwin && bus.d_req && (r_starve_hits != 16'hFFFF))
        r_starve_hits <= r_starve_hits + 1'b1;
    end
  end
`endif
endmodule
